// File: rtl/split_bus_arb_pkg.sv
// split_bus_arb_pkg: shared types, limits and helpers for the split-transaction bus arbiter.
package split_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        SPLIT_RETURN
    } arb_state_t;

    localparam int MAX_INIT          = 8;
    localparam int DEF_SPLIT_TIMEOUT = 256;

    function automatic logic [2:0] oh2idx(input logic [MAX_INIT-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_INIT; i++)
            if (oh[i]) idx = idx | 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb_picker.sv
// rr_arb_picker: combinational round-robin pick of the first requester after ptr_i (wrapping).
module rr_arb_picker #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  pick_o,
    output logic          valid_o
);

    logic [PW-1:0] idx;

    always_comb begin
        pick_o = '0;
        idx    = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(ptr_i) + i) % N);
            if (req_i[idx] && pick_o == '0) pick_o[idx] = 1'b1;
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/split_bus_arbiter.sv
// split_bus_arbiter: round-robin bus arbiter that parks an initiator on a target split
// and regrants it, with the target given priority, when split data returns.
module split_bus_arbiter
    import split_bus_arb_pkg::*;
#(
    parameter int NUM_INIT      = 2,
    parameter int SPLIT_TIMEOUT = DEF_SPLIT_TIMEOUT,
    parameter int CNT_W         = $clog2(SPLIT_TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_INIT-1:0] m_req,
    output logic [NUM_INIT-1:0] m_grant,
    output logic [NUM_INIT-1:0] m_split,
    input  logic                s_split_ack,
    input  logic                s_split_req,
    output logic                s_split_grant,
    output logic                bus_busy,
    output logic                split_timeout
);

    localparam int IW = $clog2(NUM_INIT);
    localparam int CW = (CNT_W < 1) ? 1 : CNT_W;

    arb_state_t          state_q, state_d;
    logic [NUM_INIT-1:0] grant_q, grant_d;
    logic                sgrant_q, sgrant_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       rr_q, rr_d;
    logic                pend_q, pend_d;
    logic [IW-1:0]       sown_q, sown_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                to_q, to_d;

    logic [NUM_INIT-1:0] pick;
    logic                pick_valid;
    logic [IW-1:0]       pick_idx;

    rr_arb_picker #(.N(NUM_INIT), .PW(IW)) u_picker (
        .req_i  (m_req & ~m_split),
        .ptr_i  (rr_q),
        .pick_o (pick),
        .valid_o(pick_valid)
    );

    assign pick_idx = IW'(oh2idx(MAX_INIT'(pick)));

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        sgrant_d = sgrant_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        pend_d   = pend_q;
        sown_d   = sown_q;
        cnt_d    = cnt_q;
        to_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q && s_split_req) begin
                    state_d  = SPLIT_RETURN;
                    sgrant_d = 1'b1;
                    grant_d  = NUM_INIT'(1) << sown_q;
                end else if (pick_valid) begin
                    state_d = OWNED;
                    grant_d = pick;
                    owner_d = pick_idx;
                    rr_d    = pick_idx;
                end
            end
            OWNED: begin
                // a split wins over a simultaneous release; a second split is ignored
                if (s_split_ack && !pend_q) begin
                    sown_d  = owner_q;
                    pend_d  = 1'b1;
                    cnt_d   = '0;
                    grant_d = '0;
                    state_d = IDLE;
                end else if (!m_req[owner_q]) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            SPLIT_RETURN: begin
                if (!s_split_req) begin
                    pend_d   = 1'b0;
                    grant_d  = '0;
                    sgrant_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // a return starting this cycle freezes the counter and suppresses the timeout
        if (SPLIT_TIMEOUT != 0 && pend_q && state_q != SPLIT_RETURN && state_d != SPLIT_RETURN) begin
            if (cnt_q == CW'(SPLIT_TIMEOUT - 1)) begin
                pend_d = 1'b0;
                to_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            sgrant_q <= 1'b0;
            owner_q  <= '0;
            rr_q     <= IW'(NUM_INIT - 1);
            pend_q   <= 1'b0;
            sown_q   <= '0;
            cnt_q    <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            sgrant_q <= sgrant_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            pend_q   <= pend_d;
            sown_q   <= sown_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
        end
    end

    assign m_grant       = grant_q;
    assign m_split       = pend_q ? (NUM_INIT'(1) << sown_q) : '0;
    assign s_split_grant = sgrant_q;
    assign bus_busy      = state_q != IDLE;
    assign split_timeout = to_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(m_grant));

endmodule
